// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs W-bit operations (W = 4*NIBBLES) through a 4-bit
// combinational ALU, one nibble per cycle, least-significant nibble first.
// Carry is chained between passes on the adder path (op[2]=0) and forced to
// zero between passes on the logic path (op[2]=1).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready is high only in IDLE. rsp_valid stays high until
// rsp_ready is seen, and all rsp_* hold steady while it waits.
//
// Timing: a command accepted at edge t runs its passes at edges t+1..t+NIBBLES.
// The response flag is registered, so rsp_valid rises at edge t+NIBBLES+1.
//
// Optional feature macro: ALU_SEQ_ACC_EN adds cmd_acc. When cmd_acc is high at
// acceptance, operand A is taken from the current rsp_r instead of cmd_a.
module alu_seq_ctrl #(
  parameter int NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4*NIBBLES-1:0]   cmd_a,
  input  logic [4*NIBBLES-1:0]   cmd_b,
  input  logic [2:0]             cmd_op,
  input  logic                   cmd_cin,
`ifdef ALU_SEQ_ACC_EN
  input  logic                   cmd_acc,
`endif
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [2:0]             alu_op,
  input  logic [3:0]             alu_r,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  input  logic                   alu_sign,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_r,
  output logic                   rsp_zero,
  output logic                   rsp_carry,
  output logic                   rsp_sign,
  output logic                   busy
);

  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           rsp_valid_q;
  logic           rsp_valid_d;
  logic [1:0]     k_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   r_q;
  logic [2:0]     op_q;
  logic           cin_q;
  logic           carry_q;
  logic           sign_q;
  logic           zacc_q;
  logic           accept;
  logic           last_pass;
  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic [W-1:0]   a_src;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign last_pass = (k_q == 2'(NIBBLES - 1));

`ifdef ALU_SEQ_ACC_EN
  assign a_src = cmd_acc ? r_q : cmd_a;
`else
  assign a_src = cmd_a;
`endif

  // Next-state and handshake outputs; RESP spends one settle cycle before rsp_valid.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (last_pass) state_d = RESP;
      end
      RESP: begin
        busy        = 1'b1;
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the operand nibbles for the current pass index.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == 2'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // Drive the ALU from registers; inputs are parked at zero outside EXEC.
  always_comb begin
    alu_a   = 4'd0;
    alu_b   = 4'd0;
    alu_cin = 1'b0;
    alu_op  = op_q;
    if (state_q == EXEC) begin
      alu_a = nib_a;
      alu_b = nib_b;
      if (k_q == 2'd0) alu_cin = cin_q;
      else             alu_cin = carry_q & ~op_q[2];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = r_q;
  assign rsp_zero  = zacc_q;
  assign rsp_sign  = sign_q;
  assign rsp_carry = carry_q & ~op_q[2];

  // State register, command latch and per-pass result/flag capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      k_q         <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      op_q        <= 3'd0;
      cin_q       <= 1'b0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      zacc_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        a_q    <= a_src;
        b_q    <= cmd_b;
        op_q   <= cmd_op;
        cin_q  <= cmd_cin;
        zacc_q <= 1'b1;
        k_q    <= 2'd0;
      end else if (state_q == EXEC) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == 2'(i)) r_q[4*i +: 4] <= alu_r;
        end
        zacc_q  <= zacc_q & alu_zero;
        carry_q <= alu_carry;
        sign_q  <= alu_sign;
        if (!last_pass) k_q <= k_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl (NIBBLES=2) with a behavioural 4-bit ALU attached.
module tb_alu_seq_ctrl;

  localparam int N  = 2;
  localparam int W  = 4 * N;
  localparam int EW = W + 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [2:0]   cmd_op;
  logic         cmd_cin;
  logic         cmd_acc;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic [2:0]   alu_op;
  logic [3:0]   alu_r;
  logic         alu_zero;
  logic         alu_carry;
  logic         alu_sign;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_r;
  logic         rsp_zero;
  logic         rsp_carry;
  logic         rsp_sign;
  logic         busy;
  logic [4:0]   alu_s;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int accept_cyc = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] er;
    logic         ez;
    logic         ec;
    logic         es;
  } vec_t;
  vec_t vecs[10];

  alu_seq_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_cin   (cmd_cin),
`ifdef ALU_SEQ_ACC_EN
    .cmd_acc   (cmd_acc),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_sign  (alu_sign),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
    .rsp_sign  (rsp_sign),
    .busy      (busy)
  );

  // Clock and overall time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // 4-bit ALU: 001 subtract, other op[2]=0 add; logic ops report carry=1.
  always_comb begin
    case (alu_op)
      3'b001:  alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
      3'b100:  alu_s = {1'b1, alu_a & alu_b};
      3'b101:  alu_s = {1'b1, alu_a | alu_b};
      3'b110:  alu_s = {1'b1, alu_a ^ alu_b};
      3'b111:  alu_s = {1'b1, ~alu_a};
      default: alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
    endcase
    alu_r     = alu_s[3:0];
    alu_carry = alu_s[4];
    alu_zero  = (alu_s[3:0] == 4'd0);
    alu_sign  = alu_s[3];
  end

  // Whole-word reference: {r, zero, carry, sign}.
  function automatic logic [EW-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    c = 1'b0;
    case (op)
      3'b001: begin s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin}; r = s[W-1:0]; c = s[W]; end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      3'b111: r = ~a;
      default: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; r = s[W-1:0]; c = s[W]; end
    endcase
    return {r, (r == '0), c, r[W-1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic start_cmd(input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 40) begin
      tick;
      guard++;
    end
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
    tick;
    accept_cyc = cyc_cnt;
    cmd_valid  = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_rsp;
    while (!rsp_valid && (cyc_cnt - accept_cyc) < 40) tick;
    check("rsp_valid_seen", rsp_valid, 1);
    check("rsp_latency", cyc_cnt - accept_cyc, N + 1);
  endtask

  task automatic compare_rsp;
    logic [EW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_underflow: got response r=%0h with nothing expected", rsp_r);
    end else begin
      total--;
      e = exp_q.pop_front();
      check("rsp_r", rsp_r, e[EW-1:3]);
      check("rsp_zero", rsp_zero, e[2]);
      check("rsp_carry", rsp_carry, e[1]);
      check("rsp_sign", rsp_sign, e[0]);
    end
  endtask

  task automatic finish_rsp;
    wait_rsp;
    compare_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("valid_low_after_take", rsp_valid, 0);
    check("ready_after_take", cmd_ready, 1);
  endtask

  initial begin
    logic [2:0]    op;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          rc;
    logic [3:0]    p0;
    logic [3:0]    p1;
    logic [EW-1:0] held;

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 3'd0;
    cmd_cin = 1'b0; cmd_acc = 1'b0; rsp_ready = 1'b0;

    // Reset behaviour
    tick;
    tick;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_r", rsp_r, 0);
    check("rst_flags", {rsp_zero, rsp_carry, rsp_sign}, 0);
    check("rst_alu_ab", {alu_a, alu_b}, 0);
    check("rst_alu_cin_op", {alu_cin, alu_op}, 0);
    reset = 1'b0;
    tick;
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Table of whole-word operations with hand-computed results
    vecs[0] = '{3'b000, 8'h3A, 8'h0F, 1'b0, 8'h49, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{3'b100, 8'hF0, 8'hFF, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{3'b000, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{3'b001, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{3'b101, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'b110, 8'hAA, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{3'b111, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{3'b000, 8'h80, 8'h80, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].er, vecs[i].ez, vecs[i].ec, vecs[i].es});
      start_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      finish_rsp;
    end

    // Random operations against the whole-word reference
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_model(op, ra, rb, rc));
      start_cmd(op, ra, rb, rc);
      finish_rsp;
    end

    // Add with inter-nibble carry: observe ALU drive on each pass
    exp_q.push_back({8'h49, 1'b0, 1'b0, 1'b0});
    start_cmd(3'b000, 8'h3A, 8'h0F, 1'b0);
    check("p0_alu_a", alu_a, 4'hA);
    check("p0_alu_b", alu_b, 4'hF);
    check("p0_alu_cin", alu_cin, 0);
    check("p0_alu_op", alu_op, 0);
    tick;
    check("p1_alu_a", alu_a, 4'h3);
    check("p1_alu_b", alu_b, 4'h0);
    check("p1_alu_cin", alu_cin, 1);
    finish_rsp;
    check("idle_alu_a", alu_a, 0);

    // Logic path: carry chain forced off, result assembled from passes
    exp_q.push_back({8'hF0, 1'b0, 1'b0, 1'b1});
    start_cmd(3'b100, 8'hF0, 8'hFF, 1'b0);
    check("lg_p0_cin", alu_cin, 0);
    check("lg_alu_op", alu_op, 3'b100);
    p0 = alu_r;
    tick;
    check("lg_p1_cin", alu_cin, 0);
    p1 = alu_r;
    finish_rsp;
    check("lg_assembly", rsp_r, {p1, p0});
    check("lg_hold_op", alu_op, 3'b100);

    // Backpressure: response held, new command ignored
    exp_q.push_back(ref_model(3'b000, 8'h12, 8'h34, 1'b1));
    start_cmd(3'b000, 8'h12, 8'h34, 1'b1);
    wait_rsp;
    held = {rsp_r, rsp_zero, rsp_carry, rsp_sign};
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'b001;
      cmd_a     = W'($urandom_range(0, 255));
      cmd_b     = W'($urandom_range(0, 255));
      tick;
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_stable", {rsp_r, rsp_zero, rsp_carry, rsp_sign}, held);
    end
    cmd_valid = 1'b0;
    compare_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_idle_ready", cmd_ready, 1);
    check("bp_r_holds", rsp_r, held[EW-1:3]);
    tick;
    check("bp_not_consumed", busy, 0);

    // Reset during EXEC pass 1: command discarded
    start_cmd(3'b000, 8'h55, 8'h22, 1'b0);
    tick;
    check("rst_exec_p1_alu_a", alu_a, 4'h5);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst_exec_ready", cmd_ready, 1);
    check("rst_exec_busy", busy, 0);
    check("rst_exec_rsp_r", rsp_r, 0);
    check("rst_exec_alu_a", alu_a, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rst_exec_no_rsp", rsp_valid, 0);
    end
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
